fp_align_stage: RTL and testbench
=================================

// Module: fp_align_stage
// PURPOSE
//  Pre-add alignment for the vector FP32 adder; the counterpart of the post-add normaliser.
//  - Picks the operand with the larger exponent.
//  - Right-shifts the smaller significand by the exponent difference, producing guard/round/sticky.
//  - Hands the common exponent and both aligned significands to the adder.
//  - Two-stage valid/ready pipeline, one result per cycle.
// PARAMETERS
//  EXP_W  8   exponent width
//  MAN_W  23  stored mantissa width (significand = MAN_W+1 incl. hidden bit)
//  SIG_W  MAN_W+4 (localparam)  aligned significand width: {hidden, mantissa, G, R, S}
// PORTS
//  clk_i         in   1            clock, rising edge
//  rst_ni        in   1            reset, asynchronous, active-low
//  in_valid_i    in   1            operand pair valid
//  in_ready_o    out  1            block accepts operand pair this cycle
//  a_i           in   EXP_W+MAN_W+1  operand A {sign, exp, man}
//  b_i           in   EXP_W+MAN_W+1  operand B
//  out_valid_o   out  1            aligned result valid
//  out_ready_i   in   1            downstream accepts result
//  exp_o         out  EXP_W        common (larger effective) exponent
//  sig_big_o     out  SIG_W        larger-exponent significand, GRS = 0
//  sig_small_o   out  SIG_W        smaller-exponent significand, aligned, GRS filled
//  sign_big_o    out  1            sign of larger-exponent operand
//  sign_small_o  out  1            sign of smaller-exponent operand
//  swap_o        out  1            1 = B was larger (operands swapped)
// BEHAVIOUR
//  - Reset: all pipeline valids clear; out_valid_o=0; all data outputs = 0; in_ready_o=1 after reset.
//  - Effective exponent and hidden bit:
//    - eff = (exp==0) ? 1 : exp.
//    - hidden = |exp (denormals enter with hidden=0).
//  - Stage 1, on accept:
//    - swap = (eff_b > eff_a); equal exponents keep A as big (swap=0).
//    - d = eff_big - eff_small, EXP_W bits, unsigned, never negative.
//  - Stage 2:
//    - Compute x = {hidden, man, 3'b000} for the smaller operand.
//    - sig_small = x >> d, then bit0 |= OR of all shifted-out bits.
//    - If d >= SIG_W: sig_small = {SIG_W-1 zeros, |x}.
//    - exp_o = eff_big.
//  - Latency: 2 cycles from accept (in_valid_i & in_ready_o) to out_valid_o.
//  - Throughput: 1 per cycle with out_ready_i held high.
//  - Handshake:
//    - Stage 2 advances when !s2_valid | out_ready_i.
//    - Stage 1 advances when stage 2 can load.
//    - in_ready_o = !s1_valid | s1_advance (combinational from out_ready_i; permitted).
//  - Stall: while out_valid_o & !out_ready_i, all outputs hold stable. Max 2 entries in flight; no drop, no duplicate.
//  - Simultaneous accept and drain: both happen in the same cycle, pipeline shifts.
//  - Reset mid-operation: in-flight data is discarded, out_valid_o drops immediately (async).
//  - Signs pass through unmodified. NaN/Inf are not special-cased; the exponent field is used as-is.
// CONFIGURATION
//  FP_ALIGN_STICKY_EN:
//  - Defined: bit0 of sig_small_o is the sticky OR of all shifted-out bits (round-to-nearest capable).
//  - Undefined: no sticky logic. bit0 is the plain shifted bit (truncation). d >= SIG_W gives sig_small_o=0.
// TESTING
//  1. a=0x40800000 (4.0), b=0x3F800000 (1.0)
//     -> exp_o=0x81, sig_big_o=0x4000000, sig_small_o=0x1000000, swap_o=0.
//  2. a=0x3F800000, b=0x40800000 -> same values as test 1 with swap_o=1.
//     Equal exponents (a=b=0x3F800000) -> swap_o=0, both sig=0x4000000.
//  3. a=0x4B000000, b=0x3F800001 (d=23)
//     -> sig_small_o=0x9 with FP_ALIGN_STICKY_EN, 0x8 without.
//  4. a=0x7F000000, b=0x3F800000 (d=127)
//     -> sig_small_o=0x1 with macro, 0x0 without.
//     a=b=0x00000001 (denormals) -> exp_o=1, sig=0x8.
//  5. Three back-to-back inputs with out_ready_i=0 for 4 cycles:
//     -> in_ready_o low once 2 entries are held.
//     -> outputs stable during the stall.
//     -> all 3 results emerge in order, none lost or duplicated.
//  6. Assert rst_ni=0 with both stages valid
//     -> out_valid_o=0 and outputs=0 the same cycle.
//     -> after release, first new result appears 2 cycles after accept.

Source files
------------

// File: rtl/fp_align_stage.sv
// fp_align_stage: pre-add operand alignment for the FP32 vector adder.
// Stage 1 picks the larger effective exponent and computes the shift distance.
// Stage 2 right-shifts the smaller significand and fills guard/round/sticky.
// Two-entry valid/ready pipeline; one result per cycle when downstream is ready.
// Optional feature macro: FP_ALIGN_STICKY_EN. When defined, bit0 of sig_small_o
// collects the sticky OR of all shifted-out bits. When undefined, it truncates.
module fp_align_stage #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [EXP_W+MAN_W:0]   a_i,
    input  logic [EXP_W+MAN_W:0]   b_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [EXP_W-1:0]       exp_o,
    output logic [MAN_W+3:0]       sig_big_o,
    output logic [MAN_W+3:0]       sig_small_o,
    output logic                   sign_big_o,
    output logic                   sign_small_o,
    output logic                   swap_o
);

    localparam int unsigned SIG_W = MAN_W + 4;
    localparam int unsigned HM_W  = MAN_W + 1;
    localparam logic [EXP_W-1:0] SigWExp = EXP_W'(SIG_W);

    // Stage 1 registers: selected operands and shift distance
    logic              s1_valid_q, s1_valid_d;
    logic [EXP_W-1:0]  s1_exp_q, s1_exp_d;
    logic [EXP_W-1:0]  s1_dist_q, s1_dist_d;
    logic [HM_W-1:0]   s1_big_hm_q, s1_big_hm_d;
    logic [HM_W-1:0]   s1_small_hm_q, s1_small_hm_d;
    logic              s1_sign_big_q, s1_sign_big_d;
    logic              s1_sign_small_q, s1_sign_small_d;
    logic              s1_swap_q, s1_swap_d;

    // Stage 2 registers: drive the outputs directly
    logic              s2_valid_q, s2_valid_d;
    logic [EXP_W-1:0]  s2_exp_q, s2_exp_d;
    logic [SIG_W-1:0]  s2_sig_big_q, s2_sig_big_d;
    logic [SIG_W-1:0]  s2_sig_small_q, s2_sig_small_d;
    logic              s2_sign_big_q, s2_sign_big_d;
    logic              s2_sign_small_q, s2_sign_small_d;
    logic              s2_swap_q, s2_swap_d;

    logic              s2_advance;
    logic              s1_advance;
    logic              accept;

    logic [EXP_W-1:0]  a_exp, b_exp, eff_a, eff_b;
    logic [HM_W-1:0]   a_hm, b_hm;
    logic              swap;

    logic [SIG_W-1:0]  shift_x;
    logic [SIG_W-1:0]  shifted;
    logic [SIG_W-1:0]  small_aligned;
`ifdef FP_ALIGN_STICKY_EN
    logic [SIG_W-1:0]  lost_bits;
`endif

    // Handshake: stage 1 moves whenever stage 2 can load
    always_comb begin
        s2_advance = !s2_valid_q || out_ready_i;
        s1_advance = s2_advance;
        in_ready_o = !s1_valid_q || s1_advance;
        accept     = in_valid_i && in_ready_o;
    end

    // Stage 1 next state: operand selection and exponent difference
    always_comb begin
        a_exp = a_i[EXP_W+MAN_W-1:MAN_W];
        b_exp = b_i[EXP_W+MAN_W-1:MAN_W];
        // Denormals use exponent 1 with no hidden bit
        eff_a = (a_exp == '0) ? EXP_W'(1) : a_exp;
        eff_b = (b_exp == '0) ? EXP_W'(1) : b_exp;
        a_hm  = {|a_exp, a_i[MAN_W-1:0]};
        b_hm  = {|b_exp, b_i[MAN_W-1:0]};
        swap  = (eff_b > eff_a);

        s1_valid_d      = s1_valid_q;
        s1_exp_d        = s1_exp_q;
        s1_dist_d       = s1_dist_q;
        s1_big_hm_d     = s1_big_hm_q;
        s1_small_hm_d   = s1_small_hm_q;
        s1_sign_big_d   = s1_sign_big_q;
        s1_sign_small_d = s1_sign_small_q;
        s1_swap_d       = s1_swap_q;

        if (in_ready_o) begin
            s1_valid_d = in_valid_i;
        end
        if (accept) begin
            s1_swap_d = swap;
            if (swap) begin
                s1_exp_d        = eff_b;
                s1_dist_d       = eff_b - eff_a;
                s1_big_hm_d     = b_hm;
                s1_small_hm_d   = a_hm;
                s1_sign_big_d   = b_i[EXP_W+MAN_W];
                s1_sign_small_d = a_i[EXP_W+MAN_W];
            end else begin
                s1_exp_d        = eff_a;
                s1_dist_d       = eff_a - eff_b;
                s1_big_hm_d     = a_hm;
                s1_small_hm_d   = b_hm;
                s1_sign_big_d   = a_i[EXP_W+MAN_W];
                s1_sign_small_d = b_i[EXP_W+MAN_W];
            end
        end
    end

    // Alignment shifter for the smaller significand
    always_comb begin
        shift_x = {s1_small_hm_q, 3'b000};
        shifted = shift_x >> s1_dist_q;
`ifdef FP_ALIGN_STICKY_EN
        lost_bits = shift_x & ~({SIG_W{1'b1}} << s1_dist_q);
        if (s1_dist_q >= SigWExp) begin
            small_aligned = {{(SIG_W-1){1'b0}}, |shift_x};
        end else begin
            small_aligned = shifted | {{(SIG_W-1){1'b0}}, |lost_bits};
        end
`else
        small_aligned = (s1_dist_q >= SigWExp) ? '0 : shifted;
`endif
    end

    // Stage 2 next state: load from stage 1 when the output slot frees up
    always_comb begin
        s2_valid_d      = s2_valid_q;
        s2_exp_d        = s2_exp_q;
        s2_sig_big_d    = s2_sig_big_q;
        s2_sig_small_d  = s2_sig_small_q;
        s2_sign_big_d   = s2_sign_big_q;
        s2_sign_small_d = s2_sign_small_q;
        s2_swap_d       = s2_swap_q;

        if (s2_advance) begin
            s2_valid_d = s1_valid_q;
            // Data only changes when a real entry moves in
            if (s1_valid_q) begin
                s2_exp_d        = s1_exp_q;
                s2_sig_big_d    = {s1_big_hm_q, 3'b000};
                s2_sig_small_d  = small_aligned;
                s2_sign_big_d   = s1_sign_big_q;
                s2_sign_small_d = s1_sign_small_q;
                s2_swap_d       = s1_swap_q;
            end
        end
    end

    // Pipeline state; async reset discards everything in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q      <= 1'b0;
            s1_exp_q        <= '0;
            s1_dist_q       <= '0;
            s1_big_hm_q     <= '0;
            s1_small_hm_q   <= '0;
            s1_sign_big_q   <= 1'b0;
            s1_sign_small_q <= 1'b0;
            s1_swap_q       <= 1'b0;
            s2_valid_q      <= 1'b0;
            s2_exp_q        <= '0;
            s2_sig_big_q    <= '0;
            s2_sig_small_q  <= '0;
            s2_sign_big_q   <= 1'b0;
            s2_sign_small_q <= 1'b0;
            s2_swap_q       <= 1'b0;
        end else begin
            s1_valid_q      <= s1_valid_d;
            s1_exp_q        <= s1_exp_d;
            s1_dist_q       <= s1_dist_d;
            s1_big_hm_q     <= s1_big_hm_d;
            s1_small_hm_q   <= s1_small_hm_d;
            s1_sign_big_q   <= s1_sign_big_d;
            s1_sign_small_q <= s1_sign_small_d;
            s1_swap_q       <= s1_swap_d;
            s2_valid_q      <= s2_valid_d;
            s2_exp_q        <= s2_exp_d;
            s2_sig_big_q    <= s2_sig_big_d;
            s2_sig_small_q  <= s2_sig_small_d;
            s2_sign_big_q   <= s2_sign_big_d;
            s2_sign_small_q <= s2_sign_small_d;
            s2_swap_q       <= s2_swap_d;
        end
    end

    // Outputs come straight from stage 2
    always_comb begin
        out_valid_o  = s2_valid_q;
        exp_o        = s2_exp_q;
        sig_big_o    = s2_sig_big_q;
        sig_small_o  = s2_sig_small_q;
        sign_big_o   = s2_sign_big_q;
        sign_small_o = s2_sign_small_q;
        swap_o       = s2_swap_q;
    end

endmodule

// File: tb/tb_fp_align_stage.sv
// Directed bench for fp_align_stage: alignment vectors, stall, and mid-flight reset.
// Expected values follow FP_ALIGN_STICKY_EN the same way the design does.
module tb_fp_align_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp_o;
    logic [26:0] sig_big;
    logic [26:0] sig_small;
    logic        sign_big;
    logic        sign_small;
    logic        swap;

    int n_cmp;
    int n_err;

`ifdef FP_ALIGN_STICKY_EN
    localparam logic [26:0] ExpD23  = 27'h9;
    localparam logic [26:0] ExpD127 = 27'h1;
    localparam logic [26:0] ExpD27  = 27'h1;
`else
    localparam logic [26:0] ExpD23  = 27'h8;
    localparam logic [26:0] ExpD127 = 27'h0;
    localparam logic [26:0] ExpD27  = 27'h0;
`endif

    fp_align_stage dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .a_i          (a),
        .b_i          (b),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .exp_o        (exp_o),
        .sig_big_o    (sig_big),
        .sig_small_o  (sig_small),
        .sign_big_o   (sign_big),
        .sign_small_o (sign_small),
        .swap_o       (swap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] e, input logic [26:0] sb,
                           input logic [26:0] ss, input logic sgb, input logic sgs,
                           input logic sw);
        chk({tag, "_valid"}, 32'(out_valid), 32'h1);
        chk({tag, "_exp"}, 32'(exp_o), 32'(e));
        chk({tag, "_sig_big"}, 32'(sig_big), 32'(sb));
        chk({tag, "_sig_small"}, 32'(sig_small), 32'(ss));
        chk({tag, "_sign_big"}, 32'(sign_big), 32'(sgb));
        chk({tag, "_sign_small"}, 32'(sign_small), 32'(sgs));
        chk({tag, "_swap"}, 32'(swap), 32'(sw));
    endtask

    // One isolated transaction: accept, check 2-cycle latency, check drain
    task automatic run_one(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic [7:0] e, input logic [26:0] sb, input logic [26:0] ss,
                           input logic sgb, input logic sgs, input logic sw);
        a = av;
        b = bv;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(out_valid), 32'h0);
        tick();
        chk_out(tag, e, sb, ss, sgb, sgs, sw);
        tick();
        chk({tag, "_drained"}, 32'(out_valid), 32'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_exp", 32'(exp_o), 32'h0);
        chk("rst_sig_big", 32'(sig_big), 32'h0);
        chk("rst_sig_small", 32'(sig_small), 32'h0);
        chk("rst_swap", 32'(swap), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic alignment, swap and equal-exponent cases
        run_one("t1", 32'h40800000, 32'h3F800000, 8'h81, 27'h4000000, 27'h1000000, 0, 0, 0);
        run_one("t2", 32'h3F800000, 32'h40800000, 8'h81, 27'h4000000, 27'h1000000, 0, 0, 1);
        run_one("teq", 32'h3F800000, 32'h3F800000, 8'h7F, 27'h4000000, 27'h4000000, 0, 0, 0);
        // Sticky and far-shift boundaries
        run_one("t3", 32'h4B000000, 32'h3F800001, 8'h96, 27'h4000000, ExpD23, 0, 0, 0);
        run_one("t4", 32'h7F000000, 32'h3F800000, 8'hFE, 27'h4000000, ExpD127, 0, 0, 0);
        run_one("d26", 32'h4C800000, 32'h3F800000, 8'h99, 27'h4000000, 27'h1, 0, 0, 0);
        run_one("d27", 32'h4D000000, 32'h3F800000, 8'h9A, 27'h4000000, ExpD27, 0, 0, 0);
        run_one("den", 32'h00000001, 32'h00000001, 8'h01, 27'h8, 27'h8, 0, 0, 0);
        // Signs follow their operands through the swap
        run_one("sgn", 32'hC0800000, 32'h3F800000, 8'h81, 27'h4000000, 27'h1000000, 1, 0, 0);
        run_one("sgs", 32'h3F800000, 32'hC0800000, 8'h81, 27'h4000000, 27'h1000000, 1, 0, 1);

        // Stall: three back-to-back inputs with the output blocked for 4 cycles
        out_ready = 1'b0;
        a = 32'h40800000; b = 32'h3F800000; in_valid = 1'b1;
        #1;
        chk("st_rdy0", 32'(in_ready), 32'h1);
        tick();
        a = 32'h3F800000; b = 32'h40800000;
        #1;
        chk("st_rdy1", 32'(in_ready), 32'h1);
        tick();
        a = 32'h00000001; b = 32'h00000001;
        #1;
        chk("st_rdy2", 32'(in_ready), 32'h0);
        chk_out("st_c2", 8'h81, 27'h4000000, 27'h1000000, 0, 0, 0);
        tick();
        #1;
        chk("st_rdy3", 32'(in_ready), 32'h0);
        chk_out("st_c3", 8'h81, 27'h4000000, 27'h1000000, 0, 0, 0);
        tick();
        out_ready = 1'b1;
        #1;
        chk("st_rdy4", 32'(in_ready), 32'h1);
        chk_out("st_r0", 8'h81, 27'h4000000, 27'h1000000, 0, 0, 0);
        tick();
        in_valid = 1'b0;
        chk_out("st_r1", 8'h81, 27'h4000000, 27'h1000000, 0, 0, 1);
        tick();
        chk_out("st_r2", 8'h01, 27'h8, 27'h8, 0, 0, 0);
        tick();
        chk("st_empty", 32'(out_valid), 32'h0);

        // Reset with both stages full
        out_ready = 1'b0;
        a = 32'hC0800000; b = 32'h3F800000; in_valid = 1'b1;
        tick();
        a = 32'h3F800000; b = 32'h40800000;
        tick();
        in_valid = 1'b0;
        chk("mr_full", 32'(out_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(out_valid), 32'h0);
        chk("mr_exp", 32'(exp_o), 32'h0);
        chk("mr_sig_big", 32'(sig_big), 32'h0);
        chk("mr_sig_small", 32'(sig_small), 32'h0);
        chk("mr_sign_big", 32'(sign_big), 32'h0);
        chk("mr_swap", 32'(swap), 32'h0);
        chk("mr_in_ready", 32'(in_ready), 32'h1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("mr_idle", 32'(out_valid), 32'h0);
        run_one("mr_t1", 32'h40800000, 32'h3F800000, 8'h81, 27'h4000000, 27'h1000000, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
